// File: rtl/delay_line_ram_if.sv
// rtl/delay_line_ram_if.sv - sample strobe, delay select and delayed-output bundle for delay_line_ram
interface delay_line_ram_if #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
);
    logic               en;
    logic               freeze;
    logic [A_WIDTH-1:0] offset;
    logic [D_WIDTH-1:0] din;
    logic [D_WIDTH-1:0] dout;
    logic               dout_valid;
    logic [A_WIDTH-1:0] wr_ptr;
    logic               filled;

    modport master (
        output en, freeze, offset, din,
        input  dout, dout_valid, wr_ptr, filled
    );

    modport slave (
        input  en, freeze, offset, din,
        output dout, dout_valid, wr_ptr, filled
    );
endinterface

// File: rtl/delay_line_ram.sv
// rtl/delay_line_ram.sv - circular sample buffer returning the sample written offset strobes earlier
module delay_line_ram #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8,
    parameter int OUT_REG = 0
) (
    input logic              clk,
    input logic              rst,
    delay_line_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH_CNT = (A_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {SRC_RAM, SRC_BYP, SRC_ZERO} src_t;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr_q;
    logic [A_WIDTH:0]   fill_cnt;
    logic [A_WIDTH-1:0] rd_addr;
    logic               too_old;
    logic               do_write;
    src_t               src_d;
    src_t               src_q;
    logic [D_WIDTH-1:0] ram_q;
    logic [D_WIDTH-1:0] byp_q;
    logic [D_WIDTH-1:0] dout_s1;
    logic               valid_q;

    assign do_write = bus.en & ~bus.freeze & ~rst;
    assign rd_addr  = wr_ptr_q - bus.offset;
    assign too_old  = {1'b0, bus.offset} > fill_cnt;

    // Decide at strobe time where the output comes from; unwritten history reads as zero.
    always_comb begin
        src_d = SRC_RAM;
        if (bus.offset == '0) begin
            if (!bus.freeze)
                src_d = SRC_BYP;
            else if (fill_cnt != DEPTH_CNT)
                src_d = SRC_ZERO;
        end else if (too_old) begin
            src_d = SRC_ZERO;
        end
    end

    // Read and write in one block so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (bus.en)
            ram_q <= mem[rd_addr];
        if (do_write)
            mem[wr_ptr_q] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_cnt <= '0;
            src_q    <= SRC_ZERO;
            byp_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                src_q <= src_d;
                byp_q <= bus.din;
            end
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_cnt != DEPTH_CNT)
                    fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        dout_s1 = '0;
        case (src_q)
            SRC_RAM: dout_s1 = ram_q;
            SRC_BYP: dout_s1 = byp_q;
            default: dout_s1 = '0;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [D_WIDTH-1:0] dout_r;
            logic               valid_r;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_r  <= '0;
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_q;
                    if (valid_q)
                        dout_r <= dout_s1;
                end
            end
            assign bus.dout       = dout_r;
            assign bus.dout_valid = valid_r;
        end else begin : g_no_out_reg
            assign bus.dout       = dout_s1;
            assign bus.dout_valid = valid_q;
        end
    endgenerate

    assign bus.wr_ptr = wr_ptr_q;
    assign bus.filled = (fill_cnt == DEPTH_CNT);
endmodule

// File: tb/tb_delay_line_ram.sv
// tb/tb_delay_line_ram.sv - directed checks of delay_line_ram with and without the output register
module tb_delay_line_ram;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    delay_line_ram_if #(.A_WIDTH(4), .D_WIDTH(8)) b0 ();
    delay_line_ram_if #(.A_WIDTH(4), .D_WIDTH(8)) b1 ();

    delay_line_ram #(.A_WIDTH(4), .D_WIDTH(8), .OUT_REG(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    delay_line_ram #(.A_WIDTH(4), .D_WIDTH(8), .OUT_REG(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic e, input logic [7:0] d, input logic [3:0] off, input logic frz);
        b0.en     = e;
        b0.din    = d;
        b0.offset = off;
        b0.freeze = frz;
    endtask

    logic [7:0] hist [41];
    logic [7:0] exp_d;
    logic       pat [10];
    int         n_in;
    int         n_out;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drv0(1'b0, 8'h00, 4'd0, 1'b0);
        b1.en = 1'b0; b1.din = 8'h00; b1.offset = 4'd3; b1.freeze = 1'b0;
        cyc();
        cyc();
        chk("rst_dout",   32'(b0.dout), 32'h0);
        chk("rst_valid",  32'(b0.dout_valid), 32'h0);
        chk("rst_wr_ptr", 32'(b0.wr_ptr), 32'h0);
        chk("rst_filled", 32'(b0.filled), 32'h0);
        chk("rst_dout_r", 32'(b1.dout), 32'h0);

        // Offset 3 over 20 strobes: three zeros, then the stream delayed by 3.
        rst0 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drv0(1'b1, 8'(k), 4'd3, 1'b0);
            cyc();
            chk("s1_dout",   32'(b0.dout), (k <= 3) ? 32'h0 : 32'(k - 3));
            chk("s1_valid",  32'(b0.dout_valid), 32'h1);
            chk("s1_filled", 32'(b0.filled), (k >= 16) ? 32'h1 : 32'h0);
        end
        drv0(1'b0, 8'h00, 4'd3, 1'b0);
        cyc();
        chk("idle_valid", 32'(b0.dout_valid), 32'h0);
        chk("idle_hold",  32'(b0.dout), 32'd17);

        drv0(1'b1, 8'hA5, 4'd0, 1'b0);
        cyc();
        chk("bypass_dout",  32'(b0.dout), 32'hA5);
        chk("bypass_valid", 32'(b0.dout_valid), 32'h1);

        // Fill with 0x20..0x2F, then freeze and sweep the window.
        rst0 = 1'b1;
        drv0(1'b0, 8'h00, 4'd0, 1'b0);
        cyc();
        rst0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drv0(1'b1, 8'(8'h20 + k), 4'd1, 1'b0);
            cyc();
        end
        chk("fill_wr_ptr", 32'(b0.wr_ptr), 32'h0);
        chk("fill_filled", 32'(b0.filled), 32'h1);
        for (int off = 1; off <= 15; off++) begin
            drv0(1'b1, 8'hFF, 4'(off), 1'b1);
            cyc();
            chk("frz_dout",   32'(b0.dout), 32'(8'h20 + 16 - off));
            chk("frz_wr_ptr", 32'(b0.wr_ptr), 32'h0);
        end
        drv0(1'b1, 8'hFF, 4'd0, 1'b1);
        cyc();
        chk("frz_off0_oldest", 32'(b0.dout), 32'h20);
        drv0(1'b1, 8'hFF, 4'd1, 1'b0);
        cyc();
        chk("unfrz_no_write", 32'(b0.dout), 32'h2F);

        // Forty samples at offset 15, crossing the pointer wrap twice.
        rst0 = 1'b1;
        drv0(1'b0, 8'h00, 4'd0, 1'b0);
        cyc();
        rst0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            hist[k] = 8'((k * 7 + 3) & 8'hFF);
            drv0(1'b1, hist[k], 4'd15, 1'b0);
            cyc();
            exp_d = (k > 15) ? hist[k - 15] : 8'h00;
            chk("wrap_dout", 32'(b0.dout), 32'(exp_d));
        end

        // Reset wins over a simultaneous strobe; old RAM data stays hidden.
        rst0 = 1'b1;
        drv0(1'b1, 8'h77, 4'd5, 1'b0);
        cyc();
        chk("rst_en_valid",  32'(b0.dout_valid), 32'h0);
        chk("rst_en_dout",   32'(b0.dout), 32'h0);
        chk("rst_en_wr_ptr", 32'(b0.wr_ptr), 32'h0);
        chk("rst_en_filled", 32'(b0.filled), 32'h0);
        rst0 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            drv0(1'b1, 8'(8'h50 + k), 4'd5, 1'b0);
            cyc();
            chk("post_rst_dout", 32'(b0.dout), (k <= 5) ? 32'h0 : 32'(8'h50 + k - 5));
        end
        drv0(1'b1, 8'hEE, 4'd0, 1'b1);
        cyc();
        chk("frz_off0_unfilled", 32'(b0.dout), 32'h0);
        drv0(1'b0, 8'h00, 4'd0, 1'b0);

        // Output-register instance: gapped strobes arrive two cycles later.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst1 = 1'b0;
        n_in = 0;
        n_out = 0;
        for (int c = 0; c < 10; c++) begin
            b1.en = pat[c];
            if (pat[c]) begin
                n_in++;
                b1.din = 8'(n_in);
            end
            cyc();
            chk("or_valid", 32'(b1.dout_valid), (c >= 1 && pat[c - 1]) ? 32'h1 : 32'h0);
            if (c >= 1 && pat[c - 1]) begin
                n_out++;
                chk("or_dout", 32'(b1.dout), (n_out <= 3) ? 32'h0 : 32'(n_out - 3));
            end
        end
        chk("or_count", 32'(n_out), 32'd4);

        // Reset in the cycle after a strobe discards the in-flight read.
        b1.en = 1'b1;
        b1.din = 8'h99;
        b1.offset = 4'd0;
        cyc();
        b1.en = 1'b0;
        rst1 = 1'b1;
        cyc();
        chk("inflight_valid0", 32'(b1.dout_valid), 32'h0);
        rst1 = 1'b0;
        cyc();
        chk("inflight_valid1", 32'(b1.dout_valid), 32'h0);
        chk("inflight_dout",   32'(b1.dout), 32'h0);
        chk("inflight_wr_ptr", 32'(b1.wr_ptr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
